sram_responder: RTL
===================

# sram_responder

Responder end of the CPU core's SRAM-style data port. It accepts the core's `en` / `wen` / `addr` / `wdata` requests and returns read data one cycle later. Requests are served from an internal word-organised RAM or from a small MMIO register bank (LED, free-running timer, error counter). It sits at SoC level, directly on the core's `data_sram_*` outputs, and is the stand-in memory for bring-up and directed testing of the pipeline.

## Interface
- `ADDR_W`, default 14: word-index width of the internal RAM, giving 2^ADDR_W words (64 KiB at default). Legal range 8..20.
- `MMIO_BASE`, default 32'hBFAF_0000: MMIO page base. Only bits [31:16] are compared.
- `clk`  in  1  the block's one clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sram_en`  in  1  request valid this cycle.
- `sram_wen`  in  4  byte write enables. Bit i covers `wdata[8i+7:8i]`. 0 means a read.
- `sram_addr`  in  32  byte address. Bits [1:0] are ignored.
- `sram_wdata`  in  32  write data.
- `sram_rdata`  out  32  registered read data.
- `led`  out  16  LED register contents.
- `err_cnt`  out  8  saturating count of unmapped accesses.

## Operation
- Decode is combinational on `sram_addr` when `sram_en`=1. Priority order:
  - MMIO hit: `sram_addr[31:16]` == `MMIO_BASE[31:16]`. The register is selected by `sram_addr[15:2]`.
  - RAM hit: with physical address = {3'b000, `sram_addr[28:0]`}, physical bits [28:ADDR_W+2] are all zero. The word index is `sram_addr[ADDR_W+1:2]`, so kseg0 and kseg1 alias the same RAM.
  - Otherwise the access is unmapped.
- RAM write (`wen`≠0): only enabled bytes are updated. Disabled bytes keep their value.
- RAM read (`wen`=0): the addressed word is registered into `sram_rdata`.
- MMIO registers, by offset:
  - 0x0: LED, RW. Bits [15:0] are `led`; reads return {16'b0, led}. A write honours `wen[1:0]` only.
  - 0x4: TIMER, RW, 32-bit. Increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A write replaces the enabled bytes; the timer does not increment in the write cycle.
  - 0x8: ERRCNT, RO. Reads return {24'b0, err_cnt}. Any write with `wen`≠0 clears it to 0.
  - Any other offset in the MMIO page is unmapped.
- Unmapped access:
  - Reads return 0.
  - Writes are dropped.
  - `err_cnt` increments by 1 and saturates at 0xFF.
  - A write to ERRCNT is mapped, so it does not count.
- Write cycles and idle cycles (`sram_en`=0) leave `sram_rdata` unchanged. `sram_rdata` changes only after a read request.
- No backpressure: one request is accepted every cycle, and back-to-back reads and writes are legal.

## Timing
- Read latency is exactly 1. A read presented at edge N appears on `sram_rdata` after edge N and holds until the next read is accepted.
- Write latency: state is updated at edge N. A read of the same word presented at edge N+1 returns the new data.
- RAM read-after-write to the same word in consecutive cycles needs no stall.
- TIMER read at edge N returns the pre-increment value T. The value after edge N is T+1.
- TIMER write of V at edge N gives TIMER = V after N. A read at N+1 returns V, and the value after N+1 is V+1.
- ERRCNT read-and-unmapped can never coincide: it is a single access per cycle.
- Reset (`rst`=0, asynchronous) immediately forces:
  - `sram_rdata`=0, `led`=0, TIMER=0, `err_cnt`=0.
  - RAM contents are not reset and stay undefined until written.
- Reset asserted mid-stream discards the pending read result. The first edge after release is treated as idle unless `sram_en`=1.
- Outputs are glitch-free registers. No combinational path exists from inputs to `sram_rdata`.

## Test plan
- Reset then RAM byte-write merge:
  - Assert `rst`=0 for 3 cycles: `sram_rdata`, `led` and `err_cnt` all read 0.
  - Write 0x1122_3344 to 0x8000_0010 with `wen`=4'hF, then 0xAA00_0000 with `wen`=4'h8.
  - Read 0xA000_0010 (alias) → 0xAA22_3344 one cycle later.
- Back-to-back traffic:
  - In consecutive cycles write 0xDEAD_BEEF to word 5, read word 5, read word 6 (previously 0x0000_0006).
  - `sram_rdata` = 0xDEAD_BEEF, then 0x0000_0006 on the following cycle.
  - An idle cycle afterwards holds 0x0000_0006.
- LED:
  - Write 0xFFFF_A5C3 to 0xBFAF_0000 with `wen`=4'hF → `led`=0xA5C3.
  - Read back → 0x0000_A5C3.
  - Write with `wen`=4'h2 and data 0x0000_1200 → `led`=0x12C3.
- TIMER:
  - Write 0xFFFF_FFFE to 0xBFAF_0004, then read on the next cycle → 0xFFFF_FFFE.
  - Read again 2 cycles later → 0x0000_0000 (wrap).
- Unmapped and saturation:
  - Perform 300 reads of 0x8010_0000 (ADDR_W=14) → every `sram_rdata` is 0 and `err_cnt`=0xFF.
  - Write 0 to 0xBFAF_0008 → `err_cnt`=0 and no increment for that write.
  - A write to 0xBFAF_000C → `err_cnt`=1.
- Async reset mid-read:
  - Issue a read of word 5 and pull `rst` low between edges before the next edge → `sram_rdata`=0 immediately.
  - After release with `sram_en`=0, `sram_rdata` remains 0.

Source files
------------

// File: rtl/sram_responder.sv
// SRAM-style data-port responder: word-organised RAM plus a small MMIO bank
// (LED, free-running timer, unmapped-access counter), one-cycle registered reads.
module sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    output logic [7:0]  err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] ram_mem [0:DEPTH-1];

    logic [31:0] rdata_reg;
    logic [15:0] led_reg,   led_next;
    logic [31:0] timer_reg, timer_next;
    logic [7:0]  err_reg,   err_next;

    logic [31:0]       byte_mask;
    logic [ADDR_W-1:0] ram_idx;
    logic [13:0]       mmio_off;
    logic              is_write;
    logic              mmio_hit, ram_hit;
    logic              led_sel, timer_sel, err_sel;
    logic              mapped, unmapped;
    logic              ram_wr, led_wr, timer_wr, err_wr, rd_req;
    logic [31:0]       mmio_rdata;

    // Expand the per-byte write enables into a 32-bit merge mask.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign byte_mask[8*gi +: 8] = {8{sram_wen[gi]}};
        end
    endgenerate

    // Address decode; MMIO takes priority, RAM ignores the segment bits [31:29].
    always_comb begin
        ram_idx   = sram_addr[ADDR_W+1:2];
        mmio_off  = sram_addr[15:2];
        is_write  = (sram_wen != 4'b0000);
        mmio_hit  = sram_en && (sram_addr[31:16] == MMIO_BASE[31:16]);
        ram_hit   = sram_en && !mmio_hit && (sram_addr[28:ADDR_W+2] == '0);
        led_sel   = mmio_hit && (mmio_off == 14'd0);
        timer_sel = mmio_hit && (mmio_off == 14'd1);
        err_sel   = mmio_hit && (mmio_off == 14'd2);
        mapped    = ram_hit || led_sel || timer_sel || err_sel;
        unmapped  = sram_en && !mapped;
        ram_wr    = ram_hit && is_write;
        led_wr    = led_sel && is_write;
        timer_wr  = timer_sel && is_write;
        err_wr    = err_sel && is_write;
        rd_req    = sram_en && !is_write;
    end

    always_comb begin
        mmio_rdata = 32'h0;
        if (led_sel) begin
            mmio_rdata = {16'h0, led_reg};
        end else if (timer_sel) begin
            mmio_rdata = timer_reg;
        end else if (err_sel) begin
            mmio_rdata = {24'h0, err_reg};
        end
    end

    always_comb begin
        led_next   = led_reg;
        timer_next = timer_reg + 32'd1;
        err_next   = err_reg;
        if (led_wr) begin
            led_next = (led_reg & ~byte_mask[15:0]) | (sram_wdata[15:0] & byte_mask[15:0]);
        end
        // A timer write replaces enabled bytes and suppresses that cycle's increment.
        if (timer_wr) begin
            timer_next = (timer_reg & ~byte_mask) | (sram_wdata & byte_mask);
        end
        if (err_wr) begin
            err_next = 8'h00;
        end else if (unmapped && (err_reg != 8'hFF)) begin
            err_next = err_reg + 8'd1;
        end
    end

    // RAM array: no reset, byte-lane writes.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wen[b]) begin
                    ram_mem[ram_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data only moves on a read request; writes and idle cycles hold it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= 32'h0;
        end else if (rd_req) begin
            if (ram_hit) begin
                rdata_reg <= ram_mem[ram_idx];
            end else begin
                rdata_reg <= mmio_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg   <= 16'h0;
            timer_reg <= 32'h0;
            err_reg   <= 8'h0;
        end else begin
            led_reg   <= led_next;
            timer_reg <= timer_next;
            err_reg   <= err_next;
        end
    end

    assign sram_rdata = rdata_reg;
    assign led        = led_reg;
    assign err_cnt    = err_reg;

endmodule
